// File: rtl/dram_arbiter.sv
// Data-RAM port arbiter between the CPU MEM stage and a debug/loader master.
// CPU has priority, DBG has a starvation bound, and at most one read is in flight.
module dram_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    // CPU (pipeline MEM stage)
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_cpu_stall,
    // debug / loader master
    input  logic              i_dbg_req,
    input  logic              i_dbg_we,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    input  logic [DATA_W-1:0] i_dbg_wdata,
    output logic              o_dbg_gnt,
    output logic              o_dbg_rvalid,
    output logic [DATA_W-1:0] o_dbg_rdata,
    // RAM port
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    generate
        if (RD_LAT < 0 || RD_LAT > 4) begin : g_bad_rd_lat
            $error("dram_arbiter: RD_LAT must be in 0..4");
        end
        if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
            $error("dram_arbiter: MAX_WAIT must be in 1..255");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD_CPU = 2'd1,
        ST_RD_DBG = 2'd2
    } state_t;

    localparam logic [2:0] LAT_END  = 3'(RD_LAT);
    localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);
    localparam bit         COMB_RD  = (RD_LAT == 0);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_lat_cnt;
    logic [2:0]          w_lat_cnt_nxt;
    logic [7:0]          r_wait_cnt;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [DATA_W-1:0]   r_dbg_rdata;

    logic                w_idle;
    logic                w_dbg_win;
    logic                w_cpu_win;
    logic                w_rd_start;
    logic                w_cpu_done;
    logic                w_dbg_gnt;
    logic                w_dbg_rvalid;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_wdata;
    logic [DATA_W-1:0]   w_cpu_rdata;

    // Grants are only decided in IDLE; the completion cycle of a read is not IDLE.
    assign w_idle    = (r_state == ST_IDLE);
    assign w_dbg_win = w_idle && i_dbg_req && (!i_cpu_req || (r_wait_cnt >= WAIT_LIM));
    assign w_cpu_win = w_idle && !w_dbg_win && i_cpu_req;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        w_state_nxt   = r_state;
        w_lat_cnt_nxt = r_lat_cnt;
        w_rd_start    = 1'b0;
        w_cpu_done    = 1'b0;
        w_dbg_gnt     = 1'b0;
        w_dbg_rvalid  = 1'b0;
        w_mem_we      = 1'b0;
        w_mem_addr    = '0;
        w_mem_wdata   = '0;
        w_cpu_rdata   = '0;

        case (r_state)
            ST_IDLE: begin
                if (w_dbg_win) begin
                    w_dbg_gnt   = 1'b1;
                    w_mem_we    = i_dbg_we;
                    w_mem_addr  = i_dbg_addr;
                    w_mem_wdata = i_dbg_wdata;
                    if (!i_dbg_we) begin
                        if (COMB_RD) begin
                            w_dbg_rvalid = 1'b1;
                        end else begin
                            w_rd_start    = 1'b1;
                            w_state_nxt   = ST_RD_DBG;
                            w_lat_cnt_nxt = 3'd1;
                        end
                    end
                end else if (w_cpu_win) begin
                    w_mem_we    = i_cpu_we;
                    w_mem_addr  = i_cpu_addr;
                    w_mem_wdata = i_cpu_wdata;
                    if (i_cpu_we) begin
                        w_cpu_done = 1'b1;
                    end else if (COMB_RD) begin
                        w_cpu_done  = 1'b1;
                        w_cpu_rdata = i_mem_rdata;
                    end else begin
                        w_rd_start    = 1'b1;
                        w_state_nxt   = ST_RD_CPU;
                        w_lat_cnt_nxt = 3'd1;
                    end
                end
            end

            ST_RD_CPU: begin
                w_mem_addr = r_rd_addr;
                if (r_lat_cnt == LAT_END) begin
                    w_cpu_done    = 1'b1;
                    w_cpu_rdata   = i_mem_rdata;
                    w_state_nxt   = ST_IDLE;
                    w_lat_cnt_nxt = '0;
                end else begin
                    w_lat_cnt_nxt = r_lat_cnt + 3'd1;
                end
            end

            ST_RD_DBG: begin
                w_mem_addr = r_rd_addr;
                if (r_lat_cnt == LAT_END) begin
                    w_dbg_rvalid  = 1'b1;
                    w_state_nxt   = ST_IDLE;
                    w_lat_cnt_nxt = '0;
                end else begin
                    w_lat_cnt_nxt = r_lat_cnt + 3'd1;
                end
            end

            default: begin
                w_state_nxt   = ST_IDLE;
                w_lat_cnt_nxt = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_lat_cnt   <= '0;
            r_wait_cnt  <= '0;
            r_rd_addr   <= '0;
            r_dbg_rdata <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_lat_cnt <= w_lat_cnt_nxt;
            if (w_rd_start) begin
                r_rd_addr <= w_mem_addr;
            end
            if (w_dbg_rvalid) begin
                r_dbg_rdata <= i_mem_rdata;
            end
            if (w_dbg_gnt) begin
                r_wait_cnt <= '0;
            end else if (i_dbg_req && (r_wait_cnt != 8'hFF)) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
        end
    end

    // Outputs are forced to zero while reset is held, even though IDLE decodes combinationally.
    assign o_cpu_stall  = !i_rst && i_cpu_req && !w_cpu_done;
    assign o_cpu_rdata  = i_rst ? '0 : w_cpu_rdata;
    assign o_dbg_gnt    = !i_rst && w_dbg_gnt;
    assign o_dbg_rvalid = !i_rst && w_dbg_rvalid;
    assign o_dbg_rdata  = i_rst ? '0 : (w_dbg_rvalid ? i_mem_rdata : r_dbg_rdata);
    assign o_mem_we     = !i_rst && w_mem_we;
    assign o_mem_addr   = i_rst ? '0 : w_mem_addr;
    assign o_mem_wdata  = i_rst ? '0 : w_mem_wdata;

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: scoreboard plus transaction-level reference model,
// with a second RD_LAT=3 instance used for the reset-during-read scenario.
module tb_dram_arbiter;

    localparam int LAT  = 1;
    localparam int MAXW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT (RD_LAT=1) ----------------
    logic        rst;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_stall, dbg_gnt, dbg_rvalid, mem_we;

    dram_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(LAT), .MAX_WAIT(MAXW)) u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_rdata(cpu_rdata), .o_cpu_stall(cpu_stall),
        .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
        .o_dbg_gnt(dbg_gnt), .o_dbg_rvalid(dbg_rvalid), .o_dbg_rdata(dbg_rdata),
        .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] pat(input logic [31:0] a);
        return 32'hA000_0000 ^ (a * 32'h0001_0101);
    endfunction

    // One-cycle-latency RAM; contents preloaded while reset is held
    logic [31:0] ram [0:255];
    logic [31:0] ram_raddr = '0;
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) ram[i] <= pat(32'(i * 4));
            ram[4] <= 32'hA5A5_0001;
        end else if (mem_we) begin
            ram[mem_addr[9:2]] <= mem_wdata;
        end
        ram_raddr <= mem_addr;
    end
    assign mem_rdata = ram[ram_raddr[9:2]];

    // ---------------- second DUT (RD_LAT=3) ----------------
    logic        rst3;
    logic        c3_req, c3_we, d3_req, d3_we;
    logic [31:0] c3_addr, c3_wdata, d3_addr, d3_wdata;
    logic [31:0] c3_rdata, d3_rdata, m3_addr, m3_wdata, m3_rdata;
    logic        c3_stall, d3_gnt, d3_rvalid, m3_we;

    dram_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3), .MAX_WAIT(MAXW)) u_dut3 (
        .i_clk(clk), .i_rst(rst3),
        .i_cpu_req(c3_req), .i_cpu_we(c3_we), .i_cpu_addr(c3_addr), .i_cpu_wdata(c3_wdata),
        .o_cpu_rdata(c3_rdata), .o_cpu_stall(c3_stall),
        .i_dbg_req(d3_req), .i_dbg_we(d3_we), .i_dbg_addr(d3_addr), .i_dbg_wdata(d3_wdata),
        .o_dbg_gnt(d3_gnt), .o_dbg_rvalid(d3_rvalid), .o_dbg_rdata(d3_rdata),
        .o_mem_we(m3_we), .o_mem_addr(m3_addr), .o_mem_wdata(m3_wdata), .i_mem_rdata(m3_rdata)
    );

    logic [31:0] a3_p0 = '0, a3_p1 = '0, a3_p2 = '0;
    always @(posedge clk) begin
        a3_p0 <= m3_addr;
        a3_p1 <= a3_p0;
        a3_p2 <= a3_p1;
    end
    assign m3_rdata = pat(a3_p2);

    // ---------------- scoreboard and reference model ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] model_mem [0:255];
    logic [31:0] cpu_q [$];
    logic [31:0] dbg_q [$];

    int          refused;
    int          cyc;
    int          done_at;
    bit          busy;
    bit          owner_dbg;
    logic [31:0] busy_addr;
    logic [31:0] last_dbg;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: no handshake within cycle budget at t=%0t", name, $time);
    endtask

    // Monitor: predicts each cycle from the arbitration rules and pops data on DUT handshakes
    task automatic monitor_loop();
        bit          dwin, cwin, e_gnt, e_rv, e_we, e_done, chk_wd;
        logic [31:0] e_addr, e_wd, exp_d;
        forever begin
            @(negedge clk);
            if (rst) begin
                refused = 0; busy = 0; owner_dbg = 0; last_dbg = '0; cyc = 0;
            end else begin
                cyc++;
                e_gnt = 0; e_rv = 0; e_we = 0; e_done = 0; chk_wd = 1;
                e_addr = '0; e_wd = '0;
                if (busy) begin
                    e_addr = busy_addr;
                    chk_wd = 0;
                    if (cyc == done_at) begin
                        busy = 0;
                        if (owner_dbg) e_rv = 1;
                        else           e_done = 1;
                    end
                end else begin
                    dwin = dbg_req && (!cpu_req || refused >= MAXW);
                    cwin = !dwin && cpu_req;
                    if (dwin) begin
                        e_gnt = 1; e_we = dbg_we; e_addr = dbg_addr; e_wd = dbg_wdata;
                        if (!dbg_we) begin
                            busy = 1; owner_dbg = 1; busy_addr = dbg_addr; done_at = cyc + LAT;
                        end
                    end else if (cwin) begin
                        e_we = cpu_we; e_addr = cpu_addr; e_wd = cpu_wdata;
                        if (cpu_we) e_done = 1;
                        else begin
                            busy = 1; owner_dbg = 0; busy_addr = cpu_addr; done_at = cyc + LAT;
                        end
                    end
                end
                check("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !e_done));
                check("dbg_gnt", 32'(dbg_gnt), 32'(e_gnt));
                check("dbg_rvalid", 32'(dbg_rvalid), 32'(e_rv));
                check("mem_we", 32'(mem_we), 32'(e_we));
                check("mem_addr", mem_addr, e_addr);
                if (chk_wd) check("mem_wdata", mem_wdata, e_wd);

                if (cpu_req && !cpu_we && !cpu_stall) begin
                    if (cpu_q.size() == 0) timeout_fail("cpu_rdata_unexpected");
                    else begin
                        exp_d = cpu_q.pop_front();
                        check("cpu_rdata", cpu_rdata, exp_d);
                    end
                end
                if (dbg_rvalid) begin
                    if (dbg_q.size() == 0) timeout_fail("dbg_rvalid_unexpected");
                    else begin
                        exp_d = dbg_q.pop_front();
                        check("dbg_rdata", dbg_rdata, exp_d);
                        last_dbg = exp_d;
                    end
                end else begin
                    check("dbg_rdata_hold", dbg_rdata, last_dbg);
                end

                if (e_gnt) refused = 0;
                else if (dbg_req && refused < 255) refused++;
            end
        end
    endtask

    // ---------------- stimulus tasks ----------------
    task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                              output int stalls);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        if (we) model_mem[addr[9:2]] = wd;
        else    cpu_q.push_back(model_mem[addr[9:2]]);
        stalls = 0;
        forever begin
            @(negedge clk);
            if (!cpu_stall) break;
            stalls++;
            if (stalls > 300) begin timeout_fail("cpu_access"); break; end
        end
    endtask

    task automatic cpu_idle();
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_addr = $urandom; cpu_wdata = $urandom;
    endtask

    task automatic dbg_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                              output int waits);
        @(posedge clk); #1;
        dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd;
        if (we) model_mem[addr[9:2]] = wd;
        else    dbg_q.push_back(model_mem[addr[9:2]]);
        waits = 0;
        forever begin
            @(negedge clk);
            if (dbg_gnt) break;
            waits++;
            if (waits > 300) begin timeout_fail("dbg_access"); break; end
        end
        @(posedge clk); #1;
        dbg_req = 1'b0; dbg_we = 1'b0;
        dbg_addr = $urandom; dbg_wdata = $urandom;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          s, w, s8, rv_cnt;
        logic [31:0] a;

        rst = 1'b1; rst3 = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h44; cpu_wdata = 32'hDEAD;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h48; dbg_wdata = 32'hBEEF;
        c3_req = 1'b0; c3_we = 1'b0; c3_addr = '0; c3_wdata = '0;
        d3_req = 1'b0; d3_we = 1'b0; d3_addr = '0; d3_wdata = '0;
        for (int i = 0; i < 256; i++) model_mem[i] = pat(32'(i * 4));
        model_mem[4] = 32'hA5A5_0001;
        fork monitor_loop(); join_none

        // Reset: all outputs 0 while rst is held, despite active requests
        repeat (2) @(negedge clk);
        check("rst cpu_stall", 32'(cpu_stall), 32'd0);
        check("rst dbg_gnt", 32'(dbg_gnt), 32'd0);
        check("rst mem_we", 32'(mem_we), 32'd0);
        check("rst mem_addr", mem_addr, 32'd0);
        check("rst mem_wdata", mem_wdata, 32'd0);
        check("rst dbg_rdata", dbg_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; dbg_req = 1'b0;

        // T1: lone CPU read, one stall cycle
        cpu_access(1'b0, 32'h10, 32'h0, s);
        check("T1 stall cycles", 32'(s), 32'd1);
        check("T1 cpu_rdata", cpu_rdata, 32'hA5A5_0001);
        cpu_idle();

        // T2: CPU write then read back
        cpu_access(1'b1, 32'h20, 32'h1234, s);
        check("T2 write stalls", 32'(s), 32'd0);
        cpu_access(1'b0, 32'h20, 32'h0, s);
        check("T2 readback", cpu_rdata, 32'h1234);
        cpu_idle();

        // T3: DBG read and write with CPU idle
        dbg_access(1'b0, 32'h40, 32'h0, w);
        check("T3 dbg waits", 32'(w), 32'd0);
        dbg_access(1'b1, 32'h104, 32'hCAFE_0104, w);
        dbg_access(1'b0, 32'h104, 32'h0, w);
        repeat (2) @(posedge clk);

        // T4: CPU back-to-back writes, DBG starves until the bound
        s8 = 0;
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    cpu_access(1'b1, 32'(32'h80 + 4 * i), $urandom, s);
                    if (i == 8) s8 = s;
                end
                cpu_idle();
            end
            dbg_access(1'b0, 32'h108, 32'h0, w);
        join
        check("T4 dbg waits", 32'(w), 32'(MAXW));
        check("T4 cpu stalls", 32'(s8), 32'd2);
        repeat (2) @(posedge clk);

        // T5: simultaneous requests with wait_cnt=0, CPU first
        fork
            begin cpu_access(1'b1, 32'h34, 32'h5555, s); cpu_idle(); end
            dbg_access(1'b1, 32'h10C, 32'h6666, w);
        join
        check("T5 dbg waits wr", 32'(w), 32'd1);
        repeat (2) @(posedge clk);
        fork
            begin cpu_access(1'b0, 32'h34, 32'h0, s); cpu_idle(); end
            dbg_access(1'b0, 32'h10C, 32'h0, w);
        join
        check("T5 dbg waits rd", 32'(w), 32'd2);
        repeat (2) @(posedge clk);

        // Randomized traffic, disjoint address regions per master
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    a = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
                    cpu_access(1'($urandom_range(0, 1)), a, $urandom, s);
                    if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 2)) cpu_idle();
                end
                cpu_idle();
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    a = {23'd0, 1'b1, 6'($urandom_range(0, 63)), 2'b00};
                    dbg_access(1'($urandom_range(0, 1)), a, $urandom, w);
                    repeat ($urandom_range(0, 4)) @(posedge clk);
                end
            end
        join
        repeat (4) @(posedge clk);
        check("cpu_q drained", 32'(cpu_q.size()), 32'd0);
        check("dbg_q drained", 32'(dbg_q.size()), 32'd0);

        // T6: RD_LAT=3 instance, reset in the middle of a DBG read
        @(posedge clk); #1;
        rst3 = 1'b0;
        @(posedge clk); #1;
        d3_req = 1'b1; d3_we = 1'b0; d3_addr = 32'h80;
        @(negedge clk);
        check("T6 gnt", 32'(d3_gnt), 32'd1);
        @(posedge clk); #1;
        d3_req = 1'b0;
        @(posedge clk); #1;
        rst3 = 1'b1; c3_req = 1'b1; c3_addr = 32'h90; d3_req = 1'b1; d3_addr = 32'h94;
        @(negedge clk);
        check("T6 rst stall", 32'(c3_stall), 32'd0);
        check("T6 rst gnt", 32'(d3_gnt), 32'd0);
        check("T6 rst rvalid", 32'(d3_rvalid), 32'd0);
        check("T6 rst mem_we", 32'(m3_we), 32'd0);
        check("T6 rst mem_addr", m3_addr, 32'd0);
        check("T6 rst mem_wdata", m3_wdata, 32'd0);
        check("T6 rst cpu_rdata", c3_rdata, 32'd0);
        check("T6 rst dbg_rdata", d3_rdata, 32'd0);
        @(posedge clk); #1;
        rst3 = 1'b0; c3_req = 1'b0; d3_req = 1'b0;
        rv_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (d3_rvalid) rv_cnt++;
        end
        check("T6 dropped rvalid", 32'(rv_cnt), 32'd0);

        // After reset release: DBG read with three cycles of latency
        @(posedge clk); #1;
        d3_req = 1'b1; d3_we = 1'b0; d3_addr = 32'h84;
        @(negedge clk);
        check("T6 post gnt", 32'(d3_gnt), 32'd1);
        @(posedge clk); #1;
        d3_req = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("T6 post rvalid", 32'(d3_rvalid), 32'(k == 3));
        end
        check("T6 post rdata", d3_rdata, pat(32'h84));
        @(negedge clk);
        check("T6 rdata hold", d3_rdata, pat(32'h84));

        // CPU read on the RD_LAT=3 instance
        @(posedge clk); #1;
        c3_req = 1'b1; c3_we = 1'b0; c3_addr = 32'h0C;
        s = 0;
        forever begin
            @(negedge clk);
            if (!c3_stall) break;
            s++;
            if (s > 50) begin timeout_fail("T6 cpu read"); break; end
        end
        check("T6 cpu stalls", 32'(s), 32'd3);
        check("T6 cpu rdata", c3_rdata, pat(32'h0C));
        @(posedge clk); #1;
        c3_req = 1'b0;
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
